// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared FSM state encodings and default data width for the RAM arbiter.
package ram_arb_pkg;
    localparam int WORD_WIDTH = 16;
    typedef enum logic [3:0] {
        IDLE = 4'd0,
        ADDR = 4'd1,
        WAIT = 4'd2,
        DATA = 4'd3,
        DONE = 4'd4
    } state_e;
endpackage

// File: rtl/ram_arb_rr_pick2.sv
// rr_pick2: two-way round-robin pick; on contention the requester not granted last wins.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic sel,
    output logic valid
);
    assign valid = req0 | req1;
    assign sel   = (req0 & req1) ? ~last : req1;
endmodule

// File: rtl/ram_arb.sv
// ram_arb: arbitrates a control unit and an I/O DMA onto one RAM port with
// a fixed ADDR/WAIT/DATA/DONE access sequence and round-robin priority.
module ram_arb
    import ram_arb_pkg::*;
#(
    parameter int word_width  = WORD_WIDTH,
    parameter int wait_states = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [word_width-1:0] addr0,
    input  logic [word_width-1:0] addr1,
    input  logic [word_width-1:0] wdata0,
    input  logic [word_width-1:0] wdata1,
    input  logic [word_width-1:0] ram_rdata,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [word_width-1:0] rdata,
    output logic [word_width-1:0] ram_addr,
    output logic [word_width-1:0] ram_wdata,
    output logic                  ram_oe,
    output logic                  ram_we,
    output logic [3:0]            disp_state
);
    // WAIT counts down to zero, so it is loaded with one less than its length
    localparam logic [3:0] CNT_INIT = 4'((wait_states > 0) ? wait_states - 1 : 0);

    state_e                state_q, state_d;
    logic                  own_q, last_q, we_q;
    logic [word_width-1:0] addr_q, wdata_q, rdata_q;
    logic [3:0]            cnt_q;
    logic                  pick_sel, pick_v, busy;

    rr_pick2 u_pick (
        .req0  (req0),
        .req1  (req1),
        .last  (last_q),
        .sel   (pick_sel),
        .valid (pick_v)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = pick_v ? ADDR : IDLE;
            ADDR:    state_d = (wait_states > 0) ? WAIT : DATA;
            WAIT:    state_d = (cnt_q == 4'd0) ? DATA : WAIT;
            DATA:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = state_q inside {ADDR, WAIT, DATA, DONE};
        gnt0       = busy && !own_q;
        gnt1       = busy && own_q;
        ack0       = (state_q == DONE) && !own_q;
        ack1       = (state_q == DONE) && own_q;
        ram_oe     = (state_q == DATA) && !we_q;
        ram_we     = (state_q == DATA) && we_q;
        ram_addr   = addr_q;
        ram_wdata  = wdata_q;
        rdata      = rdata_q;
        disp_state = state_q;
    end

    // last_q = 1 after reset so that requester 0 wins the first contention
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            own_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= 4'd0;
        end else begin
            if (state_q == IDLE && pick_v) begin
                own_q   <= pick_sel;
                we_q    <= pick_sel ? we1 : we0;
                addr_q  <= pick_sel ? addr1 : addr0;
                wdata_q <= pick_sel ? wdata1 : wdata0;
            end
            if (state_q == ADDR)
                cnt_q <= CNT_INIT;
            else if (state_q == WAIT && cnt_q != 4'd0)
                cnt_q <= cnt_q - 4'd1;
            if (state_q == DATA && !we_q)
                rdata_q <= ram_rdata;
            if (state_q == DONE)
                last_q <= own_q;
        end
endmodule

// File: tb/tb_ram_arb.sv
// tb_ram_arb: scoreboard bench; stimulus queues expected transactions, a monitor
// compares grants, state, strobes, acks and read data cycle by cycle.
module tb_ram_arb;
    logic clk = 0, rst = 1;
    logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [15:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0, ram_rdata = 0;
    logic        g0[3], g1[3], a0[3], a1[3], oe[3], wr[3];
    logic [15:0] rd[3], ra[3], rw[3];
    logic [3:0]  ds[3];
    int cyc = 0, act = 0, pass_n = 0, tot_n = 0;

    typedef struct {
        bit          who;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rd;
        int          ack;
    } item_t;
    item_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // instance 0: wait_states=1, 1: wait_states=0, 2: wait_states=15
    for (genvar k = 0; k < 3; k++) begin : g_dut
        ram_arb #(.word_width(16), .wait_states(k == 0 ? 1 : k == 1 ? 0 : 15)) u_dut (
            .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
            .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
            .ram_rdata(ram_rdata), .gnt0(g0[k]), .gnt1(g1[k]), .ack0(a0[k]), .ack1(a1[k]),
            .rdata(rd[k]), .ram_addr(ra[k]), .ram_wdata(rw[k]), .ram_oe(oe[k]), .ram_we(wr[k]),
            .disp_state(ds[k])
        );
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tot_n++;
        if (got === exp) pass_n++;
        else $display("FAIL %s: got %h expected %h (cycle %0d, dut %0d)", name, got, exp, cyc, act);
    endtask

    task automatic push(input bit who, input bit we, input logic [15:0] a, input logic [15:0] w,
                        input logic [15:0] r, input int ack);
        exp_q.push_back('{who: who, we: we, addr: a, wdata: w, rd: r, ack: ack});
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        item_t f;
        int ws, lo;
        logic in_w;
        logic [3:0] st;
        forever begin
            @(negedge clk or negedge rst);
            #1;
            if (!rst)
                chk("reset_outputs", {g0[act], g1[act], a0[act], a1[act], oe[act], wr[act],
                                      ra[act], rw[act], rd[act], ds[act]}, 64'd0);
            else begin
                ws = act == 0 ? 1 : act == 1 ? 0 : 15;
                if (exp_q.size() > 0) f = exp_q[0];
                lo = f.ack - 2 - ws;
                in_w = exp_q.size() > 0 && cyc >= lo && cyc <= f.ack;
                st = !in_w ? 4'd0 : cyc == f.ack ? 4'd4 : cyc == f.ack - 1 ? 4'd3 :
                     cyc == lo ? 4'd1 : 4'd2;
                chk("grant", {g0[act], g1[act]}, !in_w ? 2'b00 : f.who ? 2'b01 : 2'b10);
                chk("disp_state", ds[act], st);
                chk("oe_we_excl", oe[act] & wr[act], 1'b0);
                chk("strobe", {oe[act], wr[act]},
                    (in_w && cyc == f.ack - 1) ? (f.we ? 2'b01 : 2'b10) : 2'b00);
                if (in_w && cyc < f.ack) begin
                    chk("ram_addr", ra[act], f.addr);
                    chk("ram_wdata", rw[act], f.wdata);
                end
                if (a0[act] | a1[act]) begin
                    if (exp_q.size() == 0) chk("ack_unexpected", {a0[act], a1[act]}, 2'b00);
                    else begin
                        chk("ack_owner", {a0[act], a1[act]}, f.who ? 2'b01 : 2'b10);
                        chk("ack_cycle", cyc, f.ack);
                        chk("rdata", rd[act], f.rd);
                        void'(exp_q.pop_front());
                    end
                end else if (exp_q.size() > 0 && cyc >= f.ack) begin
                    chk("ack_missing", {a0[act], a1[act]}, f.who ? 2'b01 : 2'b10);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int c;
        #2 rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        // ws=1 read of 0x0010 returning 0xBEEF: ack at cycle 4
        c = cyc; req0 = 1; we0 = 0; addr0 = 16'h0010; ram_rdata = 16'hBEEF;
        push(0, 0, 16'h0010, 16'h0000, 16'hBEEF, c + 4);
        wait_to(c + 4); req0 = 0;
        wait_to(c + 25);
        // ws=0 write 0x1234 to 0x00FF: ack at cycle 3, rdata keeps 0xBEEF
        act = 1;
        c = cyc; req1 = 1; we1 = 1; addr1 = 16'h00FF; wdata1 = 16'h1234;
        push(1, 1, 16'h00FF, 16'h1234, 16'hBEEF, c + 3);
        wait_to(c + 3); req1 = 0;
        wait_to(c + 25);
        // ws=15 read: 15 WAIT cycles, ack at cycle 18
        act = 2;
        c = cyc; req0 = 1; we0 = 0; addr0 = 16'h0040; ram_rdata = 16'h0F0F;
        push(0, 0, 16'h0040, 16'h0000, 16'h0F0F, c + 18);
        wait_to(c + 18); req0 = 0;
        wait_to(c + 22);
        // both requesters held from reset: grants 0,1,0,1
        act = 0;
        #2 rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        c = cyc;
        req0 = 1; we0 = 0; addr0 = 16'h0020; wdata0 = 16'h0000;
        req1 = 1; we1 = 1; addr1 = 16'h0030; wdata1 = 16'h5555; ram_rdata = 16'h1111;
        push(0, 0, 16'h0020, 16'h0000, 16'h1111, c + 4);
        push(1, 1, 16'h0030, 16'h5555, 16'h1111, c + 9);
        push(0, 0, 16'h0020, 16'h0000, 16'h2222, c + 14);
        push(1, 1, 16'h0030, 16'h5555, 16'h2222, c + 19);
        wait_to(c + 5); ram_rdata = 16'h2222;
        wait_to(c + 14); req0 = 0;
        wait_to(c + 19); req1 = 0;
        wait_to(c + 22);
        // req0 dropped during WAIT: still completes, then idle grants nobody
        c = cyc; req0 = 1; we0 = 0; addr0 = 16'h0050; ram_rdata = 16'h3333;
        push(0, 0, 16'h0050, 16'h0000, 16'h3333, c + 4);
        wait_to(c + 2); req0 = 0;
        wait_to(c + 10);
        // reset mid-WAIT: transaction lost, requester 0 favoured again afterwards
        c = cyc; req0 = 1; we0 = 0; addr0 = 16'h0060; ram_rdata = 16'h6666;
        push(0, 0, 16'h0060, 16'h0000, 16'h6666, c + 4);
        wait_to(c + 2);
        #2 rst = 0; exp_q.delete(); req0 = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        c = cyc;
        req0 = 1; we0 = 0; addr0 = 16'h0070;
        req1 = 1; we1 = 1; addr1 = 16'h0080; wdata1 = 16'hABCD; ram_rdata = 16'h4444;
        push(0, 0, 16'h0070, 16'h0000, 16'h4444, c + 4);
        push(1, 1, 16'h0080, 16'hABCD, 16'h4444, c + 9);
        wait_to(c + 4); req0 = 0;
        wait_to(c + 9); req1 = 0;
        wait_to(c + 12);
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule

// File: doc/ram_arb.md
RAM_ARB -- requirements
Module: ram_arb

Interface
REQ-001 Parameter word_width, default 16, SHALL set the data and address width.
REQ-002 Parameter wait_states, default 1, range 0..15, SHALL set the RAM wait cycles inserted per access.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 req0/req1  input  1  SHALL be the access requests; requester 0 is the control unit and requester 1 is the I/O DMA.
REQ-006 we0/we1  input  1  SHALL select the access type per requester: 1 = write, 0 = read.
REQ-007 addr0/addr1  input  word_width  SHALL be the access addresses.
REQ-008 wdata0/wdata1  input  word_width  SHALL be the write data.
REQ-009 gnt0/gnt1  output  1  SHALL indicate the owner of the current transaction.
REQ-010 ack0/ack1  output  1  SHALL be a one-cycle completion pulse.
REQ-011 rdata  output  word_width  SHALL carry the read data, shared by both requesters.
REQ-012 ram_addr/ram_wdata  output  word_width  SHALL drive the RAM address and write data.
REQ-013 ram_oe/ram_we  output  1  SHALL drive the RAM read and write strobes.
REQ-014 ram_rdata  input  word_width  SHALL be the RAM read data.
REQ-015 disp_state  output  4  SHALL carry the FSM state encoding for debug display.

Function
REQ-016 FSM states SHALL be IDLE=0, ADDR=1, WAIT=2, DATA=3, DONE=4; unused encodings SHALL go to IDLE.
REQ-017 In IDLE with no request active, the FSM SHALL stay in IDLE with all strobes, grants and acks at 0.
REQ-018 In IDLE with at least one request active, the arbiter SHALL pick a winner, latch its we, addr and wdata, set its gnt and go to ADDR.
REQ-019 When both requests are active, the winner SHALL be the requester that was not granted last (round-robin).
REQ-020 After reset, priority SHALL favour requester 0.
REQ-021 Exactly one gnt SHALL be high from ADDR through DONE inclusive, and both SHALL be 0 in IDLE.
REQ-022 In ADDR, ram_addr and ram_wdata SHALL hold the latched values.
REQ-023 ram_addr and ram_wdata SHALL be held stable from ADDR through DATA.
REQ-024 ADDR SHALL move to WAIT when wait_states > 0, else to DATA.
REQ-025 WAIT SHALL last exactly wait_states cycles, counted by a down-counter, then move to DATA.
REQ-026 In DATA, ram_oe SHALL be 1 for a read or ram_we SHALL be 1 for a write, for exactly one cycle.
REQ-027 On a read, rdata SHALL capture ram_rdata at the end of the DATA cycle.
REQ-028 rdata SHALL hold its value until the next read completes; writes SHALL leave rdata unchanged.
REQ-029 In DONE, the owner's ack SHALL be high for one cycle.
REQ-030 DONE SHALL always go to IDLE, and the round-robin pointer SHALL update in DONE.
REQ-031 Latency: a request sampled in IDLE at cycle 0 SHALL produce ack at cycle 3+wait_states.
REQ-032 The next arbitration SHALL occur no earlier than cycle 4+wait_states.
REQ-033 Once granted, a transaction SHALL run to completion even if its req drops; there is no abort.
REQ-034 Requests arriving while the FSM is not in IDLE SHALL wait, with no loss; requesters SHALL hold req, we, addr and wdata until ack.
REQ-035 A requester that keeps req high after its ack SHALL be treated as a new request.
REQ-036 Under continuous requests from both sides, grants SHALL alternate strictly.
REQ-037 ram_oe and ram_we SHALL never be high together.
REQ-038 All outputs SHALL be decoded from registers only, with no combinational path from any req to any output.

Reset
REQ-039 Asserting rst (low), in any state, SHALL immediately force state=IDLE, the RR pointer to favour requester 0, the counter to 0, rdata=0, and every gnt, ack, ram_oe, ram_we, ram_addr and ram_wdata to 0.
REQ-040 A transaction cut off by reset SHALL be lost with no ack issued.
REQ-041 After reset is released, the first rising edge SHALL evaluate IDLE.

Structure
REQ-042 The state encodings and the default word_width SHALL live in a shared package (ram_arb_pkg), reused by disp_state decoding.
REQ-043 The round-robin selection SHALL be one sub-module, rr_pick2 (inputs req0, req1 and last; outputs sel and valid), with no other sub-modules.

Verification
REQ-044 The bench SHALL cover these directed scenarios:
- wait_states=1; req0 reads 0x0010, RAM returns 0xBEEF -> gnt0 from cycle 1; ram_oe high only in cycle 3; ack0 in cycle 4; rdata=0xBEEF.
- wait_states=0; req1 writes 0x1234 to 0x00FF -> ram_we high for 1 cycle with ram_addr=0x00FF and ram_wdata=0x1234; ack1 in cycle 3; rdata unchanged.
- req0 and req1 both held high from reset for 4 transactions -> grant order 0,1,0,1; never both gnt; ram_oe and ram_we never both high.
- req0 dropped in WAIT -> access still completes and ack0 pulses; the next IDLE grants nobody if no req is active.
- rst asserted low mid-WAIT -> outputs go to 0 asynchronously before the next edge; no ack; a fresh req1 after release is served with priority to 0 restored.
- wait_states=15 -> exactly 15 WAIT cycles; ack at cycle 18.
